alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 51 +++++
 rtl/alu_seq_if.sv | 34 +++
 rtl/alu_seq_flags.sv | 45 ++++
 rtl/alu_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM states, flag bundle and width helpers for alu_seq
// Build option: ALU_SEQ_MUL_EN enables the shift-add multiplier (op 0010).
package alu_seq_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_MUL = 4'b0010,
        OP_NEG = 4'b0011,
        OP_AND = 4'b1000,
        OP_XOR = 4'b1001,
        OP_OR  = 4'b1010,
        OP_NOT = 4'b1011,
        OP_ROR = 4'b1100,
        OP_ROL = 4'b1101,
        OP_SHR = 4'b1110,
        OP_SHL = 4'b1111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
        logic err;
        logic a_eq_b;
        logic a_gt_b;
        logic a_lt_b;
    } flags_t;

    function automatic int shamt_w(input int width);
        return $clog2(width);
    endfunction

    function automatic logic op_legal(input logic [3:0] op);
`ifdef ALU_SEQ_MUL_EN
        return op[3:2] != 2'b01;
`else
        return (op[3:2] != 2'b01) && (op != OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/result handshake bundle for alu_seq
interface alu_seq_if import alu_seq_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             carry;
    logic             zero;
    logic             negative;
    logic             overflow;
    logic             err;
    logic             a_eq_b;
    logic             a_gt_b;
    logic             a_lt_b;

    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, f, carry, zero, negative, overflow, err,
               a_eq_b, a_gt_b, a_lt_b
    );

    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, f, carry, zero, negative, overflow, err,
               a_eq_b, a_gt_b, a_lt_b
    );
endinterface

// File: rtl/alu_seq_flags.sv
// rtl/alu_seq_flags.sv - combinational status/compare flag generation from result and operands
module alu_seq_flags import alu_seq_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] res,
    input  logic             ext_carry,
    output flags_t           flags
);
    localparam int M = WIDTH - 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        flags        = '0;
        flags.a_eq_b = (a == b);
        flags.a_gt_b = (a > b);
        flags.a_lt_b = (a < b);
        if (!op_legal(op)) begin
            flags.err = 1'b1;
        end else begin
            flags.zero     = (res == '0);
            flags.negative = res[M];
            case (op)
                OP_ADD: begin
                    // msb carry-in recovered from the sum bit, so no second adder is needed
                    flags.carry    = (a[M] & b[M]) | ((a[M] ^ b[M]) & ~res[M]) | (cin & 1'b0);
                    flags.overflow = (a[M] == b[M]) && (res[M] != a[M]);
                end
                OP_SUB: begin
                    flags.carry    = (a < b);
                    flags.overflow = (a[M] != b[M]) && (res[M] != a[M]);
                end
                OP_NEG: begin
                    flags.carry    = (b != '0);
                    flags.overflow = (b == MOST_NEG);
                end
                OP_MUL, OP_SHR, OP_SHL: flags.carry = ext_carry;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle arithmetic/logic, bit-serial shifts, shift-add MUL
// Build option: ALU_SEQ_MUL_EN enables MUL; without it op 0010 is reported as illegal.
module alu_seq import alu_seq_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);
    localparam int SH_W  = shamt_w(WIDTH);
    localparam int CNT_W = SH_W + 1;

    state_e           state;
    logic [WIDTH-1:0] a_r, b_r, acc, f_r;
    logic             cin_r, out_valid_r;
    logic [3:0]       op_r;
    logic [CNT_W-1:0] cnt;
    flags_t           flg_r, flg;

    logic [SH_W-1:0]  amt;
    logic             go_busy, in_idle;
    logic [WIDTH-1:0] res_single, step_res, busy_res, res_sel;
    logic             step_out, busy_carry;

    assign amt     = bus.b[SH_W-1:0];
    assign in_idle = (state == S_IDLE);

    assign bus.in_ready  = in_idle && !rst;
    assign bus.out_valid = out_valid_r;
    assign bus.f         = f_r;
    assign bus.carry     = flg_r.carry;
    assign bus.zero      = flg_r.zero;
    assign bus.negative  = flg_r.negative;
    assign bus.overflow  = flg_r.overflow;
    assign bus.err       = flg_r.err;
    assign bus.a_eq_b    = flg_r.a_eq_b;
    assign bus.a_gt_b    = flg_r.a_gt_b;
    assign bus.a_lt_b    = flg_r.a_lt_b;

    always_comb begin
        res_single = '0;
        case (bus.op)
            OP_ADD: res_single = bus.a + bus.b + WIDTH'(bus.cin);
            OP_SUB: res_single = bus.a - bus.b;
            OP_NEG: res_single = '0 - bus.b;
            OP_AND: res_single = bus.a & bus.b;
            OP_XOR: res_single = bus.a ^ bus.b;
            OP_OR:  res_single = bus.a | bus.b;
            OP_NOT: res_single = ~bus.b;
            OP_ROR, OP_ROL, OP_SHR, OP_SHL: res_single = bus.a;
            default: ;
        endcase
    end

    always_comb begin
        step_res = acc;
        step_out = 1'b0;
        case (op_r)
            OP_ROR: begin step_res = {acc[0], acc[WIDTH-1:1]};         step_out = acc[0];       end
            OP_ROL: begin step_res = {acc[WIDTH-2:0], acc[WIDTH-1]};   step_out = acc[WIDTH-1]; end
            OP_SHR: begin step_res = {1'b0, acc[WIDTH-1:1]};           step_out = acc[0];       end
            OP_SHL: begin step_res = {acc[WIDTH-2:0], 1'b0};           step_out = acc[WIDTH-1]; end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] prod, mc, prod_next;
    logic [WIDTH-1:0]   mpl;

    assign prod_next  = prod + (mpl[0] ? mc : '0);
    assign busy_res   = (op_r == OP_MUL) ? prod_next[WIDTH-1:0] : step_res;
    assign busy_carry = (op_r == OP_MUL) ? |prod_next[2*WIDTH-1:WIDTH] : step_out;
    assign go_busy    = ((bus.op[3:2] == 2'b11) && (amt != '0)) || (bus.op == OP_MUL);
`else
    assign busy_res   = step_res;
    assign busy_carry = step_out;
    assign go_busy    = (bus.op[3:2] == 2'b11) && (amt != '0);
`endif

    assign res_sel = in_idle ? res_single : busy_res;

    alu_seq_flags #(.WIDTH(WIDTH)) u_flags (
        .op        (in_idle ? bus.op  : op_r),
        .a         (in_idle ? bus.a   : a_r),
        .b         (in_idle ? bus.b   : b_r),
        .cin       (in_idle ? bus.cin : cin_r),
        .res       (res_sel),
        .ext_carry (in_idle ? 1'b0    : busy_carry),
        .flags     (flg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            a_r         <= '0;
            b_r         <= '0;
            cin_r       <= 1'b0;
            op_r        <= '0;
            acc         <= '0;
            cnt         <= '0;
            f_r         <= '0;
            flg_r       <= '0;
            out_valid_r <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            prod        <= '0;
            mc          <= '0;
            mpl         <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    a_r   <= bus.a;
                    b_r   <= bus.b;
                    cin_r <= bus.cin;
                    op_r  <= bus.op;
                    if (go_busy) begin
                        state <= S_BUSY;
                        acc   <= bus.a;
`ifdef ALU_SEQ_MUL_EN
                        prod  <= '0;
                        mc    <= {{WIDTH{1'b0}}, bus.a};
                        mpl   <= bus.b;
                        cnt   <= (bus.op == OP_MUL) ? CNT_W'(WIDTH) : {1'b0, amt};
`else
                        cnt   <= {1'b0, amt};
`endif
                    end else begin
                        f_r         <= res_sel;
                        flg_r       <= flg;
                        out_valid_r <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_BUSY: begin
                    acc <= step_res;
                    cnt <= cnt - 1'b1;
`ifdef ALU_SEQ_MUL_EN
                    prod <= prod_next;
                    mc   <= mc << 1;
                    mpl  <= mpl >> 1;
`endif
                    // the last step's result is committed directly, saving a cycle
                    if (cnt == CNT_W'(1)) begin
                        f_r         <= res_sel;
                        flg_r       <= flg;
                        out_valid_r <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: if (bus.out_ready) begin
                    out_valid_r <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
